// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider for the 16-bit datapath.
// One quotient bit is resolved per clock. A start pulse accepted in IDLE
// launches a division; busy stays high until the single-cycle done pulse.
`timescale 1ns/1ps

module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvsr;
  logic             zero_pend;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] part_next;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The subtraction only
  // needs WIDTH bits because a fitting trial always leaves a result below
  // the divisor.
  always_comb begin
    trial     = {part, shreg[WIDTH-1]};
    fits      = (trial >= {1'b0, dvsr});
    part_next = fits ? (trial[WIDTH-1:0] - dvsr) : trial[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the handshake outputs derived from the state.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on acceptance, then iterate once per RUN
  // cycle. A zero divisor spends a single RUN cycle loading the fixed
  // all-ones quotient and the dividend as remainder, so its done pulse comes
  // one cycle after acceptance instead of after WIDTH iterations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      part      <= '0;
      shreg     <= '0;
      dvsr      <= '0;
      zero_pend <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      dvsr      <= divisor;
      shreg     <= dividend;
      part      <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      zero_pend <= (divisor == '0);
      count     <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
    end else if (state == RUN) begin
      if (zero_pend) begin
        quotient  <= '1;
        remainder <= shreg;
        div_zero  <= 1'b1;
      end else begin
        part     <= part_next;
        shreg    <= {shreg[WIDTH-2:0], 1'b0};
        quotient <= {quotient[WIDTH-2:0], fits};
        if (count == '0) begin
          remainder <= part_next;
        end
      end
      if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector bench for seq_divider with hand-computed
// quotients, remainders and latencies.
`timescale 1ns/1ps

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, expv, expv);
    end
  endtask

  // Issue one start pulse, optionally pulse a second start mid-run, and wait
  // (bounded) for done. lat counts rising edges from the start cycle up to
  // the one after which done is seen.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input int intrudeAt, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      if (lat == intrudeAt) begin
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input int lat, input int expLat,
                             input logic [15:0] q, input logic [15:0] r, input logic z);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " done"}, done, 1'b1);
    checkOutput({tag, " busy"}, busy, 1'b1);
    checkOutput({tag, " quotient"}, quotient, q);
    checkOutput({tag, " remainder"}, remainder, r);
    checkOutput({tag, " div_zero"}, div_zero, z);
  endtask

  initial begin
    int lat;
    int sawDone;
    int cyc;
    int last;
    int nd;
    int lowCnt;

    #1;
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset quotient", quotient, 16'd0);
    checkOutput("reset remainder", remainder, 16'd0);
    checkOutput("reset div_zero", div_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 100/7: quotient 14, remainder 2, done 17 cycles after start.
    applyStimulus(16'd100, 16'd7, 0, lat);
    checkResult("100/7", lat, 17, 16'd14, 16'd2, 1'b0);
    @(negedge clk);
    checkOutput("100/7 done single", done, 1'b0);
    checkOutput("100/7 idle busy", busy, 1'b0);
    checkOutput("100/7 held q", quotient, 16'd14);
    checkOutput("100/7 held r", remainder, 16'd2);

    // Extremes of the operand range.
    applyStimulus(16'hFFFF, 16'h0001, 0, lat);
    checkResult("FFFF/1", lat, 17, 16'hFFFF, 16'h0000, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 0, lat);
    checkResult("FFFF/FFFF", lat, 17, 16'd1, 16'd0, 1'b0);

    // Divide by zero takes the fast path; the next division clears the flag.
    applyStimulus(16'd5, 16'd0, 0, lat);
    checkResult("5/0", lat, 2, 16'hFFFF, 16'd5, 1'b1);
    @(negedge clk);
    checkOutput("5/0 held div_zero", div_zero, 1'b1);
    applyStimulus(16'd8, 16'd2, 0, lat);
    checkResult("8/2", lat, 17, 16'd4, 16'd0, 1'b0);

    // Dividend below divisor, with an ignored start (9/3) at cycle 5.
    applyStimulus(16'd3, 16'd10, 5, lat);
    checkResult("3/10 ignored start", lat, 17, 16'd0, 16'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("3/10 stays idle", busy, 1'b0);
    checkOutput("3/10 held q", quotient, 16'd0);
    checkOutput("3/10 held r", remainder, 16'd3);

    // Asynchronous reset at cycle 8 of 1000/9 aborts without a done pulse.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("abort busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort done", done, 1'b0);
    checkOutput("abort quotient", quotient, 16'd0);
    checkOutput("abort remainder", remainder, 16'd0);
    checkOutput("abort div_zero", div_zero, 1'b0);
    sawDone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) sawDone++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) sawDone++;
    end
    checkOutput("abort no done", sawDone, 0);
    applyStimulus(16'd1000, 16'd9, 0, lat);
    checkResult("1000/9", lat, 17, 16'd111, 16'd1, 1'b0);

    // Start held high: back-to-back 50/6 divisions 18 cycles apart.
    @(negedge clk);
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd6;
    start    = 1'b1;
    cyc    = 0;
    last   = 0;
    nd     = 0;
    lowCnt = 0;
    while (nd < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!busy) lowCnt++;
      if (done) begin
        checkOutput("b2b quotient", quotient, 16'd8);
        checkOutput("b2b remainder", remainder, 16'd2);
        checkOutput("b2b div_zero", div_zero, 1'b0);
        if (nd == 0) begin
          checkOutput("b2b first latency", cyc, 17);
        end else begin
          checkOutput("b2b spacing", cyc - last, 18);
          checkOutput("b2b busy low cycles", lowCnt, 1);
        end
        lowCnt = 0;
        last   = cyc;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("b2b done count", nd, 3);
    repeat (3) @(negedge clk);
    checkOutput("b2b ends idle", busy, 1'b0);
    checkOutput("b2b held q", quotient, 16'd8);
    checkOutput("b2b held r", remainder, 16'd2);

    // Reset clears held results.
    rst_n = 1'b0;
    #1;
    checkOutput("final reset quotient", quotient, 16'd0);
    checkOutput("final reset remainder", remainder, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
